// File: rtl/ex_muldiv_sequencer.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer (1 bit/cycle) owning HI/LO; MTHI/MTLO write in 1 cycle.
// Latency: start edge + NB_DATA iterations + 1 sign-fix cycle; divide-by-zero aborts after 1 cycle.
// HI/LO instructions stall while busy; MULDIV_DIV_ZERO_FLAG_EN adds a sticky o_div_zero output.
module ex_muldiv_sequencer #(
    parameter int NB_DATA   = 32,
    parameter int NB_FUNCT  = 6,
    parameter int NB_ALU_OP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
    input  logic [NB_FUNCT-1:0]  i_funct,
    input  logic [NB_DATA-1:0]   i_rs_data,
    input  logic [NB_DATA-1:0]   i_rt_data,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_busy,
    output logic [NB_DATA-1:0]   o_hilo_rdata,
    output logic [NB_DATA-1:0]   o_hi,
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    output logic                 o_div_zero,
`endif
    output logic [NB_DATA-1:0]   o_lo
);

    localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_ALU_OP-1:0] ALU_OP_RTYPE = NB_ALU_OP'(4'b0010);
    localparam logic [NB_FUNCT-1:0]  F_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0]  F_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0]  F_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0]  F_MTLO  = NB_FUNCT'(6'b010011);
    localparam logic [NB_FUNCT-1:0]  F_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0]  F_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0]  F_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0]  F_DIVU  = NB_FUNCT'(6'b011011);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state;
    logic [NB_DATA-1:0]   hi_q;
    logic [NB_DATA-1:0]   lo_q;
    logic [NB_DATA-1:0]   reg_a;      // product high half / partial remainder
    logic [NB_DATA-1:0]   reg_b;      // multiplier / dividend shifting into quotient
    logic [NB_DATA-1:0]   reg_op;     // multiplicand / divisor magnitude
    logic [NB_CNT-1:0]    cnt;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_op;
    logic                 div_zero_pend;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    logic                 div_zero_q;
`endif

    logic rtype;
    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic start_op, hilo_op, idle, accept;
    logic signed_op, rs_neg, rt_neg;
    logic [NB_DATA-1:0] abs_rs, abs_rt;

    assign rtype     = i_valid && (i_alu_op_CU == ALU_OP_RTYPE);
    assign is_mult   = rtype && (i_funct == F_MULT);
    assign is_multu  = rtype && (i_funct == F_MULTU);
    assign is_div    = rtype && (i_funct == F_DIV);
    assign is_divu   = rtype && (i_funct == F_DIVU);
    assign is_mfhi   = rtype && (i_funct == F_MFHI);
    assign is_mflo   = rtype && (i_funct == F_MFLO);
    assign is_mthi   = rtype && (i_funct == F_MTHI);
    assign is_mtlo   = rtype && (i_funct == F_MTLO);
    assign start_op  = is_mult || is_multu || is_div || is_divu;
    assign hilo_op   = start_op || is_mfhi || is_mflo || is_mthi || is_mtlo;
    assign idle      = (state == S_IDLE);
    assign accept    = idle && !i_flush;

    assign signed_op = is_mult || is_div;
    assign rs_neg    = signed_op && i_rs_data[NB_DATA-1];
    assign rt_neg    = signed_op && i_rt_data[NB_DATA-1];
    assign abs_rs    = rs_neg ? -i_rs_data : i_rs_data;
    assign abs_rt    = rt_neg ? -i_rt_data : i_rt_data;

    assign o_stall   = i_valid && hilo_op && !idle;
    assign o_busy    = !idle;
    assign o_hi      = hi_q;
    assign o_lo      = lo_q;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    assign o_div_zero = div_zero_q;
`endif

    always_comb begin
        o_hilo_rdata = '0;
        if (!o_stall && is_mfhi) begin
            o_hilo_rdata = hi_q;
        end else if (!o_stall && is_mflo) begin
            o_hilo_rdata = lo_q;
        end
    end

    // Datapath for one iteration and for the final sign correction.
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA:0]     div_shift;
    logic [NB_DATA:0]     div_diff;
    logic [2*NB_DATA-1:0] prod_fix;
    logic [NB_DATA-1:0]   q_fix;
    logic [NB_DATA-1:0]   r_fix;
    logic                 last_iter;

    always_comb begin
        mul_sum   = {1'b0, reg_a} + (reg_b[0] ? {1'b0, reg_op} : '0);
        div_shift = {reg_a, reg_b[NB_DATA-1]};
        div_diff  = div_shift - {1'b0, reg_op};
        prod_fix  = neg_q ? -{reg_a, reg_b} : {reg_a, reg_b};
        q_fix     = neg_q ? -reg_b : reg_b;
        r_fix     = neg_r ? -reg_a : reg_a;
        last_iter = (cnt == NB_CNT'(NB_DATA - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            hi_q          <= '0;
            lo_q          <= '0;
            reg_a         <= '0;
            reg_b         <= '0;
            reg_op        <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_op        <= 1'b0;
            div_zero_pend <= 1'b0;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
            div_zero_q    <= 1'b0;
`endif
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && start_op) begin
                        div_op        <= is_div || is_divu;
                        div_zero_pend <= (is_div || is_divu) && (i_rt_data == '0);
                        neg_q         <= rs_neg ^ rt_neg;
                        neg_r         <= rs_neg;
                        cnt           <= '0;
                        reg_a         <= '0;
                        if (is_div || is_divu) begin
                            reg_b  <= abs_rs;
                            reg_op <= abs_rt;
                            state  <= S_DIV;
                        end else begin
                            reg_b  <= abs_rt;
                            reg_op <= abs_rs;
                            state  <= S_MUL;
                        end
`ifdef MULDIV_DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end else if (accept && (is_mthi || is_mtlo)) begin
                        if (is_mthi) begin
                            hi_q <= i_rs_data;
                        end else begin
                            lo_q <= i_rs_data;
                        end
`ifdef MULDIV_DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                S_MUL: begin
                    reg_a <= mul_sum[NB_DATA:1];
                    reg_b <= {mul_sum[0], reg_b[NB_DATA-1:1]};
                    cnt   <= cnt + NB_CNT'(1);
                    if (last_iter) begin
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (div_zero_pend) begin
                        div_zero_pend <= 1'b0;
                        state         <= S_IDLE;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
                        div_zero_q    <= 1'b1;
`endif
                    end else begin
                        // Restoring step: keep the shifted remainder on borrow.
                        if (div_diff[NB_DATA]) begin
                            reg_a <= div_shift[NB_DATA-1:0];
                            reg_b <= {reg_b[NB_DATA-2:0], 1'b0};
                        end else begin
                            reg_a <= div_diff[NB_DATA-1:0];
                            reg_b <= {reg_b[NB_DATA-2:0], 1'b1};
                        end
                        cnt <= cnt + NB_CNT'(1);
                        if (last_iter) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (div_op) begin
                        lo_q <= q_fix;
                        hi_q <= r_fix;
                    end else begin
                        hi_q <= prod_fix[2*NB_DATA-1:NB_DATA];
                        lo_q <= prod_fix[NB_DATA-1:0];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: multiply/divide results, stall, flush, reset, divide-by-zero.
module tb_ex_muldiv_sequencer;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [3:0]  i_alu_op_CU;
    logic [5:0]  i_funct;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic [31:0] o_hilo_rdata;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    logic        o_div_zero;
`endif

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    ex_muldiv_sequencer #(.NB_DATA(32), .NB_FUNCT(6), .NB_ALU_OP(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_alu_op_CU  (i_alu_op_CU),
        .i_funct      (i_funct),
        .i_rs_data    (i_rs_data),
        .i_rt_data    (i_rt_data),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_busy       (o_busy),
        .o_hilo_rdata (o_hilo_rdata),
        .o_hi         (o_hi),
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        .o_div_zero   (o_div_zero),
`endif
        .o_lo         (o_lo)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt);
        i_valid     = 1'b1;
        i_alu_op_CU = op;
        i_funct     = f;
        i_rs_data   = rs;
        i_rt_data   = rt;
    endtask

    task automatic bubble;
        i_valid     = 1'b0;
        i_alu_op_CU = 4'b0000;
        i_funct     = 6'b000000;
        i_rs_data   = 32'h0;
        i_rt_data   = 32'h0;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        drive(4'b0010, f, rs, rt);
        tick;
        bubble;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            tick;
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        bubble;
        tick;
        tick;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", o_lo); end
        checks++; if (o_hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", o_hilo_rdata); end
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        checks++; if (o_div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", o_div_zero); end
`endif
        i_rst_n = 1'b1;
        tick;
    endtask

    task automatic test_mult_signed;
        int n;
        issue(F_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_idle(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", n); end
        checks++; if (o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", o_hi); end
        checks++; if (o_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", o_lo); end
    endtask

    task automatic test_div;
        int n;
        issue(F_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 33", n); end
        checks++; if (o_lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", o_lo); end
        checks++; if (o_hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", o_hi); end
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (o_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", o_lo); end
        checks++; if (o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", o_hi); end
    endtask

    task automatic test_stall;
        int n;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(4'b0010, F_MFLO, 32'h0, 32'h0);
        #1;
        checks++; if (o_hilo_rdata !== 32'h0) begin errors++; $display("FAIL stall_rdata_zero: got %h want 0", o_hilo_rdata); end
        n = 0;
        while (o_stall && n < 100) begin
            n++;
            tick;
        end
        checks++; if (n !== 33) begin errors++; $display("FAIL stall_cycles: got %0d want 33", n); end
        checks++; if (o_hilo_rdata !== 32'h0000_0001) begin errors++; $display("FAIL mflo_after_stall: got %h want 00000001", o_hilo_rdata); end
        checks++; if (o_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", o_hi); end
        tick;
        bubble;
    endtask

    task automatic test_non_hilo;
        int n;
        issue(F_MULTU, 32'd3, 32'd4);
        drive(4'b0010, F_ADD, 32'd1, 32'd2);
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL add_no_stall: got %b want 0", o_stall); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", o_busy); end
        tick;
        drive(4'b0000, F_MFLO, 32'h0, 32'h0);
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL non_rtype_no_stall: got %b want 0", o_stall); end
        bubble;
        wait_idle(n);
        checks++; if (o_lo !== 32'd12) begin errors++; $display("FAIL multu_small_lo: got %h want 0000000c", o_lo); end
        checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL multu_small_hi: got %h want 0", o_hi); end
    endtask

    task automatic test_div_zero;
        issue(F_MTHI, 32'h11, 32'h0);
        checks++; if (o_hi !== 32'h11) begin errors++; $display("FAIL mthi: got %h want 00000011", o_hi); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", o_busy); end
        issue(F_MTLO, 32'h22, 32'h0);
        checks++; if (o_lo !== 32'h22) begin errors++; $display("FAIL mtlo: got %h want 00000022", o_lo); end
        drive(4'b0010, F_MFHI, 32'h0, 32'h0);
        #1;
        checks++; if (o_hilo_rdata !== 32'h11) begin errors++; $display("FAIL mfhi_read: got %h want 00000011", o_hilo_rdata); end
        bubble;
        tick;
        issue(F_DIV, 32'd5, 32'd0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dz_busy_first: got %b want 1", o_busy); end
        tick;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL dz_busy_second: got %b want 0", o_busy); end
        checks++; if (o_hi !== 32'h11) begin errors++; $display("FAIL dz_hi: got %h want 00000011", o_hi); end
        checks++; if (o_lo !== 32'h22) begin errors++; $display("FAIL dz_lo: got %h want 00000022", o_lo); end
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        checks++; if (o_div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_set: got %b want 1", o_div_zero); end
        tick;
        checks++; if (o_div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_sticky: got %b want 1", o_div_zero); end
        issue(F_MTLO, 32'h22, 32'h0);
        checks++; if (o_div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear: got %b want 0", o_div_zero); end
`endif
    endtask

    task automatic test_flush_reset;
        issue(F_MULT, 32'd3, 32'd5);
        repeat (9) tick;
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", o_busy); end
        repeat (40) tick;
        checks++; if (o_hi !== 32'h11) begin errors++; $display("FAIL flush_hi: got %h want 00000011", o_hi); end
        checks++; if (o_lo !== 32'h22) begin errors++; $display("FAIL flush_lo: got %h want 00000022", o_lo); end
        issue(F_MULT, 32'd3, 32'd5);
        repeat (9) tick;
        i_rst_n = 1'b0;
        tick;
        i_rst_n = 1'b1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", o_lo); end
        tick;
    endtask

    task automatic test_overflow_and_flush_start;
        int n;
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++; if (o_lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h want 80000000", o_lo); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h want 0", o_hi); end
        drive(4'b0010, F_MULT, 32'd7, 32'd9);
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        bubble;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", o_busy); end
        repeat (40) tick;
        checks++; if (o_lo !== 32'h8000_0000) begin errors++; $display("FAIL flush_start_lo: got %h want 80000000", o_lo); end
        drive(4'b0010, F_MTHI, 32'hABCD, 32'h0);
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        bubble;
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL flush_mthi: got %h want 0", o_hi); end
    endtask

    initial begin
        test_reset;
        test_mult_signed;
        test_div;
        test_stall;
        test_non_hilo;
        test_div_zero;
        test_flush_reset;
        test_overflow_and_flush_start;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
EX-stage controller that sequences MULT/MULTU/DIV/DIVU over an iterative 1-bit-per-cycle shift-add/restoring-subtract engine and owns the HI/LO registers. Services MFHI/MFLO/MTHI/MTLO. Stalls the pipeline when a HI/LO-dependent R-type instruction arrives while an operation is in flight. Sits beside the ALU control decode and uses the same ALUOp/funct encoding.

Parameters:
NB_DATA, 32, operand/HI/LO width; iteration count = NB_DATA
NB_FUNCT, 6, funct field width
NB_ALU_OP, 4, ALUOp width from control unit

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  EX holds a real instruction (not bubble)
i_alu_op_CU  in  NB_ALU_OP  ALUOp; only 4'b0010 (R-type) qualifies
i_funct  in  NB_FUNCT  R-type funct
i_rs_data  in  NB_DATA  rs operand (dividend / multiplicand / MTHI/MTLO source)
i_rt_data  in  NB_DATA  rt operand (divisor / multiplier)
i_flush  in  1  abort in-flight op, drop current instruction
o_stall  out  1  freeze IF/ID/EX, insert bubble into MEM
o_busy  out  1  operation in flight
o_hilo_rdata  out  NB_DATA  HI (MFHI) or LO (MFLO), else 0
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock i_clk, reset i_rst_n.
- Decode (only when i_valid and ALUOp==4'b0010): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Any other funct/ALUOp: no effect.
- Reset (i_rst_n=0 at edge): state IDLE; HI, LO, counter, internal regs = 0; o_stall=0, o_busy=0, o_hilo_rdata=0. Reset mid-operation abandons it; HI/LO = 0.
- FSM: IDLE -> MUL or DIV on accepted start; MUL/DIV -> FIX after NB_DATA iterations; FIX -> IDLE.
- Start at edge T (IDLE, start op, no flush): latch |rs|, |rt| (raw for unsigned), result signs, counter=0.
- Cycles T+1..T+NB_DATA: one iteration each. FIX cycle T+NB_DATA+1: apply signs, write HI/LO at its closing edge. New HI/LO visible from cycle T+NB_DATA+2. o_busy=1 during T+1..T+NB_DATA+1.
- MUL: 2*NB_DATA-bit product; HI = upper, LO = lower. Signed: negate product if operand signs differ.
- DIV: LO = quotient, HI = remainder. Signed: quotient negated if signs differ; remainder takes dividend sign. Truncates toward zero.
- Divide by zero (rt==0): no iteration; DIV -> IDLE next cycle; HI/LO unchanged; o_busy for 1 cycle.
- Signed -2^(NB_DATA-1)/-1: LO=0x80000000, HI=0 (wraps, no trap).
- MTHI/MTLO in IDLE: write rs at edge, 1 cycle, no stall. MFHI/MFLO in IDLE: o_hilo_rdata combinational from current HI/LO.
- o_stall = i_valid & hilo_op & (state!=IDLE), combinational. Stalled instruction is held and re-evaluated every cycle. Non-HI/LO instructions never stall; they proceed while the engine runs.
- Start requires IDLE. An op stalled behind the engine starts in the first IDLE cycle.
- i_flush: any state -> IDLE next edge; HI/LO unchanged; same-cycle start/MTHI/MTLO suppressed. Flush wins over start.
- o_hilo_rdata = 0 when stalled or not MFHI/MFLO.

Optional Feature:
MULDIV_DIV_ZERO_FLAG_EN
- Defined: adds output o_div_zero (1 bit). Reset 0. Set at the edge leaving the divide-by-zero DIV cycle. Cleared at the next accepted start or MTHI/MTLO. Sticky otherwise.
- Undefined: port absent. Divide-by-zero behaviour otherwise identical.

Test Plan:
1. MULT rs=0xFFFFFFFD(-3), rt=5 -> o_busy 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1 visible at T+34.
2. DIVU rs=100, rt=7 -> LO=14, HI=2. DIV rs=0xFFFFFFF9(-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. MULTU 0xFFFFFFFF*0xFFFFFFFF, then MFLO at T+1 -> o_stall=1 for cycles T+1..T+33; MFLO reads 0x00000001 at T+34 (HI=0xFFFFFFFE); an ADD issued during busy is not stalled.
4. DIV rt=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> HI/LO unchanged; busy 1 cycle; o_div_zero=1 if enabled.
5. Start MULT, assert i_flush at T+10 -> IDLE at T+11, HI/LO unchanged. Repeat with i_rst_n=0 at T+10 -> HI=LO=0, o_busy=0.
6. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; simultaneous start+flush -> no start, o_busy stays 0.
